alu_req_arbiter: RTL and testbench
==================================

Name: alu_req_arbiter

Overview:
- Shares one combinational 4-bit ALU (A, B, 3-bit sel → 8-bit result, carry, zero) between two requesters.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The arbiter grants round-robin, registers operands, drives the ALU, captures its outputs, and returns them to the granted requester.
- Exactly one transaction is in flight at a time.

Parameters:
- DATA_W, 4, operand width; must equal ALU operand width.
- OP_W, 3, opcode width; must equal ALU sel width.
- RES_W, 8, ALU result width.
- CNT_W, 8, width of completed-operation counter.

Ports:
- clk  input  1  clock; all state on rising edge
- rst  input  1  synchronous reset, active high
- req_valid  input  2  request valid, bit i = requester i
- req_ready  output  2  request accepted, bit i = requester i
- req0_a, req0_b  input  DATA_W each  operands, requester 0
- req0_op  input  OP_W  opcode, requester 0
- req1_a, req1_b  input  DATA_W each  operands, requester 1
- req1_op  input  OP_W  opcode, requester 1
- rsp_valid  output  2  response valid, bit i = requester i
- rsp_ready  input  2  response accepted, bit i
- rsp_result  output  RES_W  captured ALU result (shared bus)
- rsp_carry  output  1  captured carry
- rsp_zero  output  1  captured zero
- alu_a, alu_b  output  DATA_W each  to ALU A, B
- alu_sel  output  OP_W  to ALU sel
- alu_result  input  RES_W  from ALU
- alu_carry, alu_zero  input  1 each  from ALU
- busy  output  1  high in any state but IDLE
- grant_id  output  1  requester owning current transaction
- op_count  output  CNT_W  completed transactions, wraps

Behaviour:
- States: IDLE, EXEC, RESP. Encoding is free.
- Reset (rst=1 at a clk edge):
  - state=IDLE, priority pointer=0, grant_id=0, op_count=0, busy=0.
  - Operand/opcode registers, rsp_result, rsp_carry, rsp_zero all 0.
  - rsp_valid=0 and req_ready=0 combinationally while in reset state.
- IDLE:
  - req_ready[i] = (state==IDLE) && winner==i. Combinational, at most one bit set.
  - Winner: only one valid bit set → that requester; both set → requester at the priority pointer.
  - Handshake (valid&ready) latches the winner's a/b/op and grant_id=winner, then → EXEC.
  - No valid bit set → stay in IDLE.
- EXEC (exactly 1 cycle):
  - alu_a/alu_b/alu_sel come from the operand registers at all times, so the ALU is stable from EXEC onward.
  - At the end of EXEC, alu_result/alu_carry/alu_zero are captured into the rsp_* registers → RESP.
- RESP:
  - rsp_valid[grant_id]=1, other bit 0. rsp_* held stable.
  - On rsp_ready[grant_id]=1: op_count+1 (wraps at 2^CNT_W-1 → 0), priority pointer = ~grant_id, → IDLE.
  - rsp_ready of the non-granted bit is ignored.
  - Requests arriving during EXEC/RESP are held off (req_ready=0). A requester must keep valid and operands stable until ready.
- Latency: accept at cycle N, rsp_valid at N+2. Minimum 3 cycles per transaction when the response is accepted immediately.
- Fairness: both requesters continuously valid → grants alternate 0,1,0,1…
- Priority pointer changes only on response completion, never on a request-side idle cycle.
- Reset mid-transaction (EXEC or RESP): transaction discarded, no response, op_count=0, next grant follows pointer=0.
- Response back-pressure of any length is allowed; no timeout.
- The ALU is opcode-agnostic: the arbiter never decodes op.

Test Plan:
- Single request: r0 a=3, b=5, op=0, rsp_ready held 1 → req_ready[0] in accept cycle, rsp_valid[0] exactly 2 cycles later with ALU outputs for 3,5,op0. op_count=1, busy low after.
- Simultaneous requests after reset: both valid from reset release → r0 granted first, then r1. op_count=2. rsp_valid never has both bits set.
- Sustained contention: both valid for 10 transactions → grant order 0,1,0,1,…, 5 each, op_count=10.
- Back-pressure: rsp_ready[1]=0 for 6 cycles after rsp_valid[1] → rsp_result/carry/zero constant, req_ready=0 throughout. Completes the cycle rsp_ready[1]=1.
- Reset mid-operation: assert rst in EXEC and again in RESP → next cycle idle, no rsp_valid, op_count=0, pending r1 request then granted before r0 if only r1 valid.
- Counter wrap: 256 completed transactions → op_count returns to 0.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter that lends one combinational ALU to two valid/ready requesters.
// One transaction is in flight at a time: IDLE accepts, EXEC runs the ALU, RESP returns the result.
module alu_req_arbiter #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 3,
  parameter int RES_W  = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic              rsp_carry,
  output logic              rsp_zero,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_sel,
  input  logic [RES_W-1:0]  alu_result,
  input  logic              alu_carry,
  input  logic              alu_zero,
  output logic              busy,
  output logic              grant_id,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e              state_q;
  logic                ptr_q;
  logic                grant_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [OP_W-1:0]     op_q;
  logic [RES_W-1:0]    res_q;
  logic                carry_q, zero_q;

  logic                winner;
  logic [DATA_W-1:0]   win_a, win_b;
  logic [OP_W-1:0]     win_op;

  // A lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    winner = ptr_q;
    if (req_valid == 2'b01) winner = 1'b0;
    else if (req_valid == 2'b10) winner = 1'b1;
  end

  assign win_a  = winner ? req1_a  : req0_a;
  assign win_b  = winner ? req1_b  : req0_b;
  assign win_op = winner ? req1_op : req0_op;

  always_comb begin
    req_ready = '0;
    if (!rst && state_q == IDLE && req_valid[winner]) req_ready[winner] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (!rst && state_q == RESP) rsp_valid[grant_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      grant_q <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (|(req_valid & req_ready)) begin
          a_q     <= win_a;
          b_q     <= win_b;
          op_q    <= win_op;
          grant_q <= winner;
          state_q <= EXEC;
        end
        EXEC: begin
          res_q   <= alu_result;
          carry_q <= alu_carry;
          zero_q  <= alu_zero;
          state_q <= RESP;
        end
        // Pointer hands priority to the other requester only once a response completes.
        RESP: if (rsp_ready[grant_q]) begin
          cnt_q   <= cnt_q + CNT_W'(1);
          ptr_q   <= ~grant_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_sel    = op_q;
  assign rsp_result = res_q;
  assign rsp_carry  = carry_q;
  assign rsp_zero   = zero_q;
  assign busy       = (state_q != IDLE);
  assign grant_id   = grant_q;
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: a reference ALU stub, a response scoreboard
// and a small grant/counter model checked on every cycle.
module tb_alu_req_arbiter;

  logic       clk, rst;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b;
  logic [2:0] req0_op, req1_op, alu_sel;
  logic [7:0] rsp_result, alu_result, op_count;
  logic       rsp_carry, rsp_zero, alu_carry, alu_zero, busy, grant_id;

  alu_req_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sel(alu_sel), .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_zero(alu_zero), .busy(busy), .grant_id(grant_id), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: returns {carry, zero, result}.
  function automatic logic [9:0] alu_f(logic [3:0] a, logic [3:0] b, logic [2:0] op);
    logic [8:0] t;
    logic       c;
    c = 1'b0;
    case (op)
      3'd0: begin t = {5'd0, a} + {5'd0, b}; c = t[4]; end
      3'd1: begin t = {5'd0, a} - {5'd0, b}; c = t[4]; end
      3'd2: t = {5'd0, a & b};
      3'd3: t = {5'd0, a | b};
      3'd4: t = {5'd0, a ^ b};
      3'd5: t = {5'd0, a} * {5'd0, b};
      3'd6: t = {5'd0, a} << b[1:0];
      default: t = {5'd0, ~a};
    endcase
    return {c, (t[7:0] == 8'd0), t[7:0]};
  endfunction

  always_comb {alu_carry, alu_zero, alu_result} = alu_f(alu_a, alu_b, alu_sel);

  typedef struct { bit id; logic [7:0] res; logic c; logic z; int acc; } exp_t;
  exp_t       q[$];
  bit         glog[$];
  int         n_asrt = 0, n_fail = 0, cyc = 0, ndone = 0;
  logic [7:0] exp_cnt = 8'd0;
  bit         exp_ptr = 1'b0, seen = 1'b0;
  bit   [1:0] keep = 2'b00;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample just before the rising edge, update the model, then re-drive after the falling edge.
  task automatic step();
    logic [1:0] hs;
    logic [9:0] f;
    exp_t       e;
    hs = 2'b00;
    #1;
    cyc++;
    chk("op_count", op_count, exp_cnt);
    if (rst) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      q.delete();
      exp_cnt = 8'd0;
      exp_ptr = 1'b0;
      seen    = 1'b0;
    end else begin
      chk("rsp_onehot", ($countones(rsp_valid) <= 1), 1);
      if (busy) chk("hold_off", req_ready, 0);
      else if (req_valid == 2'b11) chk("rr_ptr", req_ready, 2'b01 << exp_ptr);
      else chk("rr_single", req_ready, req_valid);
      if (rsp_valid != 2'b00) begin
        if (q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
        else begin
          e = q[0];
          chk("rsp_id", rsp_valid, 2'b01 << e.id);
          chk("grant_id", grant_id, e.id);
          chk("rsp_result", rsp_result, e.res);
          chk("rsp_carry", rsp_carry, e.c);
          chk("rsp_zero", rsp_zero, e.z);
          if (!seen) begin chk("latency", cyc - e.acc, 2); seen = 1'b1; end
          if (rsp_ready[e.id]) begin
            void'(q.pop_front());
            glog.push_back(e.id);
            ndone++;
            exp_cnt++;
            exp_ptr = ~e.id;
            seen    = 1'b0;
          end
        end
      end
      hs = req_valid & req_ready;
      if (hs != 2'b00) begin
        f = hs[1] ? alu_f(req1_a, req1_b, req1_op) : alu_f(req0_a, req0_b, req0_op);
        q.push_back('{id: hs[1], res: f[7:0], c: f[9], z: f[8], acc: cyc});
      end
    end
    @(negedge clk);
    if (hs[0]) begin
      if (keep[0]) begin
        req0_a = 4'($urandom_range(0, 15)); req0_b = 4'($urandom_range(0, 15)); req0_op = 3'($urandom_range(0, 7));
      end else req_valid[0] = 1'b0;
    end
    if (hs[1]) begin
      if (keep[1]) begin
        req1_a = 4'($urandom_range(0, 15)); req1_b = 4'($urandom_range(0, 15)); req1_op = 3'($urandom_range(0, 7));
      end else req_valid[1] = 1'b0;
    end
  endtask

  task automatic run_idle(int max);
    int n = 0;
    while ((q.size() != 0 || req_valid != 2'b00) && n < max) begin step(); n++; end
    chk("idle_timeout", (n >= max), 0);
  endtask

  task automatic run_done(int target, int max);
    int n = 0;
    while (ndone < target && n < max) begin step(); n++; end
    chk("done_timeout", (n >= max), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
  endtask

  initial begin
    int base, ones, n;
    logic [7:0] held;
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b11;
    req0_a = 4'd0; req0_b = 4'd0; req0_op = 3'd0;
    req1_a = 4'd0; req1_b = 4'd0; req1_op = 3'd0;
    step(); step(); rst = 1'b0;

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_sel", alu_sel, 0);

    // Single request, 3 + 5 op 0
    req0_a = 4'd3; req0_b = 4'd5; req0_op = 3'd0; req_valid = 2'b01;
    #1 chk("single_ready", req_ready, 2'b01);
    run_idle(20);
    chk("single_result", rsp_result, 8'd8);
    chk("single_count", op_count, 1);
    chk("single_busy", busy, 0);

    // Simultaneous requests from reset release
    rst = 1'b1;
    req0_a = 4'd7; req0_b = 4'd2; req0_op = 3'd1;
    req1_a = 4'd6; req1_b = 4'd3; req1_op = 3'd5;
    req_valid = 2'b11;
    step(); rst = 1'b0;
    base = glog.size();
    run_idle(30);
    chk("sim_first", glog[base], 0);
    chk("sim_second", glog[base+1], 1);
    chk("sim_count", op_count, 2);

    // Sustained contention for 10 transactions
    do_reset();
    keep = 2'b11; req_valid = 2'b11;
    base = glog.size();
    run_done(ndone + 10, 100);
    req_valid = 2'b00; keep = 2'b00;
    ones = 0;
    for (int i = 0; i < 10; i++) begin
      chk("alternate", glog[base+i], i % 2);
      ones += int'(glog[base+i]);
    end
    chk("cont_ones", ones, 5);
    chk("cont_count", op_count, 10);

    // Response back-pressure on requester 1; rsp_ready[0] high must be ignored
    req1_a = 4'd9; req1_b = 4'd7; req1_op = 3'd1; req_valid = 2'b10; rsp_ready = 2'b01;
    n = 0;
    while (!rsp_valid[1] && n < 10) begin step(); n++; end
    chk("bp_rsp_seen", rsp_valid, 2'b10);
    held = rsp_result;
    req0_a = 4'd15; req0_b = 4'd15; req0_op = 3'd0; req_valid = 2'b01;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("bp_hold_result", rsp_result, held);
      chk("bp_hold_ready", req_ready, 0);
    end
    base = ndone;
    rsp_ready = 2'b11;
    step();
    chk("bp_complete", ndone - base, 1);
    run_idle(20);

    // Reset during EXEC and during RESP
    req0_a = 4'd1; req0_b = 4'd1; req0_op = 3'd2; req_valid = 2'b01;
    run_idle(20);
    req1_a = 4'd4; req1_b = 4'd4; req1_op = 3'd4; req_valid = 2'b10;
    step();
    chk("exec_busy", busy, 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rexec_busy", busy, 0);
    chk("rexec_rsp", rsp_valid, 0);
    chk("rexec_count", op_count, 0);
    req_valid = 2'b10; rsp_ready = 2'b00;
    step(); step();
    chk("resp_valid", rsp_valid, 2'b10);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rresp_busy", busy, 0);
    chk("rresp_rsp", rsp_valid, 0);
    chk("rresp_count", op_count, 0);
    rsp_ready = 2'b11; req_valid = 2'b10;
    step();
    chk("post_rst_grant", grant_id, 1);
    run_idle(20);

    // Counter wrap after 256 completions
    do_reset();
    keep = 2'b01; req_valid = 2'b01;
    base = ndone;
    run_done(base + 256, 1200);
    req_valid = 2'b00; keep = 2'b00;
    chk("wrap_done", ndone - base, 256);
    chk("wrap_count", op_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
